// File: rtl/spi_master_multi_pkg.sv
// spi_pkg: shared types for the multi-slave SPI master.
//   state_t     - transfer FSM states
//   spi_mode_t  - per-transfer mode latched on accept
//   cs_width()  - chip-select index width, never below 1 bit
package spi_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

    function automatic int cs_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_multi_clk_gen.sv
// spi_clk_gen: half-period tick generator for the SPI master.
//   clk, rst_n : system clock, synchronous active-low reset
//   enable     : counting allowed; low clears the counter and the edge count
//   clk_div    : half-period is clk_div+1 clk cycles
//   tick       : high on the last cycle of each half-period
//   edge_cnt   : number of half-periods completed since enable rose
module spi_clk_gen #(
    parameter int DIV_W  = 16,
    parameter int EDGE_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              tick,
    output logic [EDGE_W-1:0] edge_cnt
);

    logic [DIV_W-1:0] cnt;

    // Wrapping on equality keeps an all-ones divider from overflowing.
    assign tick = enable && (cnt == clk_div);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            edge_cnt <= '0;
        end else if (!enable) begin
            cnt      <= '0;
            edge_cnt <= '0;
        end else if (tick) begin
            cnt      <= '0;
            edge_cnt <= edge_cnt + EDGE_W'(1);
        end else begin
            cnt      <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// spi_master_multi: runtime-configurable SPI master with multiple chip selects.
//   clk, rst_n          : system clock, synchronous active-low reset
//   start               : transfer request, accepted only while busy=0
//   tx_data, cs_sel     : word and slave index, latched on accept
//   cpol, cpha          : SPI mode, latched on accept
//   lsb_first, clk_div  : bit order and half-period (clk_div+1), latched on accept
//   busy, done          : transfer in progress / one-cycle completion pulse
//   rx_data             : last received word, updated with done
//   sclk, mosi, miso    : SPI bus (miso already synchronised)
//   cs_n                : active-low chip selects; out-of-range index selects none
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 16,
    parameter int CS_W   = cs_width(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int                EDGE_W    = $clog2(2 * DATA_W + 2);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

    state_t              state;
    spi_mode_t           mode;
    logic [DIV_W-1:0]    div_q;
    logic [DATA_W-1:0]   tx_sr;
    logic [DATA_W-1:0]   rx_sr;
    logic [DATA_W-1:0]   tx_seq;
    logic [DATA_W-1:0]   rx_word;
    logic [NUM_CS-1:0]   cs_dec;
    logic                tick;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [EDGE_W-1:0]   nxt_edge;

    assign busy     = (state != S_IDLE);
    assign nxt_edge = edge_cnt + EDGE_W'(1);

    spi_clk_gen #(
        .DIV_W  (DIV_W),
        .EDGE_W (EDGE_W)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (busy),
        .clk_div  (div_q),
        .tick     (tick),
        .edge_cnt (edge_cnt)
    );

    // Both shift registers work MSB-first in "wire order"; lsb_first is
    // handled by reversing the word on the way in and on the way out.
    always_comb begin
        tx_seq  = '0;
        rx_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            tx_seq[i]  = lsb_first      ? tx_data[DATA_W-1-i] : tx_data[i];
            rx_word[i] = mode.lsb_first ? rx_sr[DATA_W-1-i]   : rx_sr[i];
        end
    end

    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            cs_dec[i] = (cs_sel != CS_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            mode    <= '0;
            div_q   <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= '1;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mode  <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
                        div_q <= clk_div;
                        sclk  <= cpol;
                        cs_n  <= cs_dec;
                        mosi  <= tx_seq[DATA_W-1];
                        rx_sr <= '0;
                        // cpha=1 re-drives the first bit on the first leading
                        // edge, so it keeps it in the register; cpha=0 has
                        // already consumed it.
                        tx_sr <= cpha ? tx_seq : {tx_seq[DATA_W-2:0], 1'b0};
                        state <= S_SETUP;
                    end
                end
                S_SETUP, S_SHIFT: begin
                    if (tick) begin
                        sclk <= ~sclk;
                        // Odd edge = leading. Sample where leading XOR cpha,
                        // otherwise advance (never after the final edge).
                        if (nxt_edge[0] ^ mode.cpha) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], miso};
                        end else if (nxt_edge != LAST_EDGE) begin
                            mosi  <= tx_sr[DATA_W-1];
                            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                        state <= (nxt_edge == LAST_EDGE) ? S_HOLD : S_SHIFT;
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        cs_n    <= '1;
                        rx_data <= rx_word;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
